// File: rtl/ped_crossing_ctrl_pkg.sv
// Shared definitions for the pedestrian crossing controller: state encodings,
// the registered lamp bundle and the car-lamp legality check.
package ped_crossing_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_REQ      = 3'd1;
  localparam logic [2:0] ST_CLEAR_IN = 3'd2;
  localparam logic [2:0] ST_WALK     = 3'd3;
  localparam logic [2:0] ST_FLASH    = 3'd4;
  localparam logic [2:0] ST_SAFE     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_REQ      = ST_REQ,
    S_CLEAR_IN = ST_CLEAR_IN,
    S_WALK     = ST_WALK,
    S_FLASH    = ST_FLASH,
    S_SAFE     = ST_SAFE
  } state_t;

  typedef struct packed {
    logic req;
    logic wait_lamp;
    logic walk;
    logic dontwalk;
    logic err;
  } lamps_t;

  // Exactly one of V/A/R lit, and the pedestrian-side B lamp tracks V.
  function automatic logic lamp_legal(input logic b, input logic a,
                                      input logic r, input logic v);
    logic exactly_one;
    exactly_one = (v ^ a ^ r) & ~(v & a & r);
    return exactly_one & (b == v);
  endfunction

  // Lamp pattern presented on entry to each state; FLASH starts with WALK lit.
  function automatic lamps_t lamps_of(input state_t s);
    lamps_t l;
    l = '{req: 1'b0, wait_lamp: 1'b0, walk: 1'b0, dontwalk: 1'b1, err: 1'b0};
    case (s)
      S_REQ: begin
        l.req       = 1'b1;
        l.wait_lamp = 1'b1;
      end
      S_CLEAR_IN: l.wait_lamp = 1'b1;
      S_WALK, S_FLASH: begin
        l.walk     = 1'b1;
        l.dontwalk = 1'b0;
      end
      S_SAFE: l.err = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioning: 2-flop synchroniser, saturating run-length counter,
// and a one-cycle pulse on the rising edge of the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

  logic          sync1_reg;
  logic          sync2_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_d_reg;
  logic          level;

  assign level = (cnt_reg == CNT_MAX);
  assign press = level & ~level_d_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      cnt_reg     <= '0;
      level_d_reg <= 1'b0;
    end else begin
      sync1_reg   <= btn;
      sync2_reg   <= sync1_reg;
      level_d_reg <= level;
      // Any low sample restarts the run; a full run holds at the ceiling.
      if (!sync2_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian end of the crossing link: issues the crossing request and drives
// the pedestrian lamps from the car lamps returned by the car-light controller.
module ped_crossing_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int FLASH_HALF = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  input  logic B,
  input  logic A,
  input  logic R,
  input  logic V,
  output logic T,
  output logic WAIT,
  output logic WALK,
  output logic DONTWALK,
  output logic ERR
);
  import ped_crossing_ctrl_pkg::*;

  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

  state_t        state_reg;
  lamps_t        lamps_reg;
  logic [FW-1:0] flash_cnt_reg;
  logic          press;
  logic          legal;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .CLK  (CLK),
    .RST  (RST),
    .btn  (BTN),
    .press(press)
  );

  assign legal = lamp_legal(B, A, R, V);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= S_IDLE;
      lamps_reg     <= lamps_of(S_IDLE);
      flash_cnt_reg <= '0;
    end else if (state_reg == S_SAFE || !legal) begin
      // An illegal pattern overrides whatever transition was due this edge.
      state_reg <= S_SAFE;
      lamps_reg <= lamps_of(S_SAFE);
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (press) begin
            state_reg <= S_REQ;
            lamps_reg <= lamps_of(S_REQ);
          end
        end
        S_REQ: begin
          if (A && !V) begin
            state_reg <= S_CLEAR_IN;
            lamps_reg <= lamps_of(S_CLEAR_IN);
          end
        end
        S_CLEAR_IN: begin
          if (R) begin
            state_reg <= S_WALK;
            lamps_reg <= lamps_of(S_WALK);
          end
        end
        S_WALK: begin
          if (A) begin
            state_reg     <= S_FLASH;
            lamps_reg     <= lamps_of(S_FLASH);
            flash_cnt_reg <= '0;
          end else if (V) begin
            state_reg <= S_IDLE;
            lamps_reg <= lamps_of(S_IDLE);
          end
        end
        S_FLASH: begin
          if (V) begin
            state_reg <= S_IDLE;
            lamps_reg <= lamps_of(S_IDLE);
          end else if (flash_cnt_reg == FLASH_LAST) begin
            flash_cnt_reg  <= '0;
            lamps_reg.walk <= ~lamps_reg.walk;
          end else begin
            flash_cnt_reg <= flash_cnt_reg + FW'(1);
          end
        end
        default: begin
          state_reg <= S_SAFE;
          lamps_reg <= lamps_of(S_SAFE);
        end
      endcase
    end
  end

  assign T        = lamps_reg.req;
  assign WAIT     = lamps_reg.wait_lamp;
  assign WALK     = lamps_reg.walk;
  assign DONTWALK = lamps_reg.dontwalk;
  assign ERR      = lamps_reg.err;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Scoreboard bench for ped_crossing_ctrl: each driven cycle queues the lamp
// vector expected after the next edge, which is popped and compared at edge+1.
module tb_ped_crossing_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic BTN = 1'b0;
  logic B = 1'b1, A = 1'b0, R = 1'b0, V = 1'b1;
  logic T, WAIT, WALK, DONTWALK, ERR;

  int vectors     = 0;
  int miscompares = 0;
  logic [4:0] exp_q[$];

  // Output vectors ordered {T, WAIT, WALK, DONTWALK, ERR}
  localparam logic [4:0] O_IDLE      = 5'b00010;
  localparam logic [4:0] O_REQ       = 5'b11010;
  localparam logic [4:0] O_CLR       = 5'b01010;
  localparam logic [4:0] O_WALK      = 5'b00100;
  localparam logic [4:0] O_FLASH_ON  = 5'b00100;
  localparam logic [4:0] O_FLASH_OFF = 5'b00000;
  localparam logic [4:0] O_SAFE      = 5'b00011;

  // Car lamp vectors ordered {B, A, R, V}
  localparam logic [3:0] L_V     = 4'b1001;
  localparam logic [3:0] L_A     = 4'b0100;
  localparam logic [3:0] L_R     = 4'b0010;
  localparam logic [3:0] L_V_NOB = 4'b0001;
  localparam logic [3:0] L_AR    = 4'b0110;
  localparam logic [3:0] L_A_B   = 4'b1100;

  ped_crossing_ctrl #(
    .DEB_CYCLES(4),
    .FLASH_HALF(2)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .BTN     (BTN),
    .B       (B),
    .A       (A),
    .R       (R),
    .V       (V),
    .T       (T),
    .WAIT    (WAIT),
    .WALK    (WALK),
    .DONTWALK(DONTWALK),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [4:0] outs();
    return {T, WAIT, WALK, DONTWALK, ERR};
  endfunction

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: T/WAIT/WALK/DONTWALK/ERR got %b expected %b (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: T/WAIT/WALK/DONTWALK/ERR = %b (t=%0t)", tag, got, $time);
    end
  endtask

  task automatic pop_and_chk(input string tag);
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: scoreboard empty, got %b expected an entry", tag, outs());
    end else begin
      e = exp_q.pop_front();
      chk(tag, outs(), e);
    end
  endtask

  // Drive one cycle of stimulus and check the outputs one edge later.
  task automatic cyc(input string tag, input logic btn, input logic [3:0] lmp, input logic [4:0] exp);
    BTN = btn;
    {B, A, R, V} = lmp;
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    pop_and_chk(tag);
  endtask

  task automatic run(input string tag, input int n, input logic btn, input logic [3:0] lmp, input logic [4:0] exp);
    for (int i = 0; i < n; i++) begin
      cyc($sformatf("%s[%0d]", tag, i), btn, lmp, exp);
    end
  endtask

  // Asynchronous reset: outputs must be at reset values before any clock edge.
  task automatic apply_reset(input string tag);
    BTN = 1'b0;
    {B, A, R, V} = L_V;
    RST = 1'b0;
    #2;
    exp_q.push_back(O_IDLE);
    pop_and_chk(tag);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  initial begin
    #1;
    // 1: reset and quiet idle
    apply_reset("reset_init");
    run("t1_idle", 20, 1'b0, L_V, O_IDLE);

    // 2: bounces never reach four clean samples; R alone opens nothing
    for (int i = 0; i < 5; i++) begin
      run($sformatf("t2_bounce%0d_hi", i), 3, 1'b1, L_V, O_IDLE);
      cyc($sformatf("t2_bounce%0d_lo", i), 1'b0, L_V, O_IDLE);
    end
    run("t2_quiet", 6, 1'b0, L_V, O_IDLE);
    run("t2_r_only", 4, 1'b0, L_R, O_IDLE);
    run("t2_back_v", 2, 1'b0, L_V, O_IDLE);

    // 3: press latency and request hold until amber
    run("t3_deb", 6, 1'b1, L_V, O_IDLE);
    cyc("t3_req", 1'b1, L_V, O_REQ);
    run("t3_req_hold", 4, 1'b1, L_V, O_REQ);
    cyc("t3_clear", 1'b1, L_A, O_CLR);

    // 4: full crossing with BTN still held throughout
    run("t4_walk", 10, 1'b1, L_R, O_WALK);
    for (int k = 0; k < 8; k++) begin
      cyc($sformatf("t4_flash[%0d]", k), 1'b1, L_A, (((k / 2) % 2) == 0) ? O_FLASH_ON : O_FLASH_OFF);
    end
    cyc("t4_done", 1'b1, L_V, O_IDLE);
    run("t4_level_held", 10, 1'b1, L_V, O_IDLE);

    // 5: press during WALK is dropped; fresh press works; press in REQ absorbed
    run("t5_release", 4, 1'b0, L_V, O_IDLE);
    run("t5_deb", 6, 1'b1, L_V, O_IDLE);
    cyc("t5_req", 1'b1, L_V, O_REQ);
    cyc("t5_clear", 1'b1, L_A, O_CLR);
    run("t5_walk", 3, 1'b1, L_R, O_WALK);
    run("t5_walk_rel", 4, 1'b0, L_R, O_WALK);
    run("t5_walk_press", 8, 1'b1, L_R, O_WALK);
    run("t5_flash", 2, 1'b1, L_A, O_FLASH_ON);
    cyc("t5_done", 1'b1, L_V, O_IDLE);
    run("t5_no_rereq", 10, 1'b1, L_V, O_IDLE);
    run("t5_release2", 4, 1'b0, L_V, O_IDLE);
    run("t5_deb2", 6, 1'b1, L_V, O_IDLE);
    cyc("t5_req2", 1'b1, L_V, O_REQ);
    run("t5_req_rel", 4, 1'b0, L_V, O_REQ);
    run("t5_req_press", 8, 1'b1, L_V, O_REQ);
    cyc("t5_clear2", 1'b1, L_A, O_CLR);
    cyc("t5_walk2", 1'b0, L_R, O_WALK);
    apply_reset("t5_reset_mid_walk");
    run("t5_after_reset", 3, 1'b0, L_V, O_IDLE);

    // 6: illegal lamps from IDLE, coinciding with a transition, and from WALK
    cyc("t6_vnob", 1'b0, L_V_NOB, O_SAFE);
    run("t6_safe_hold", 5, 1'b0, L_V, O_SAFE);
    run("t6_safe_btn", 8, 1'b1, L_V, O_SAFE);
    apply_reset("t6_reset_safe1");
    run("t6_deb", 6, 1'b1, L_V, O_IDLE);
    cyc("t6_req", 1'b1, L_V, O_REQ);
    cyc("t6_coincide", 1'b1, L_A_B, O_SAFE);
    run("t6_coincide_hold", 4, 1'b0, L_A, O_SAFE);
    apply_reset("t6_reset_safe2");
    run("t6_deb2", 6, 1'b1, L_V, O_IDLE);
    cyc("t6_req2", 1'b1, L_V, O_REQ);
    cyc("t6_clear2", 1'b1, L_A, O_CLR);
    run("t6_walk2", 2, 1'b0, L_R, O_WALK);
    cyc("t6_ar", 1'b0, L_AR, O_SAFE);
    run("t6_ar_hold", 4, 1'b0, L_R, O_SAFE);
    apply_reset("t6_reset_final");
    run("t6_final_idle", 3, 1'b0, L_V, O_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
